// File: rtl/avalon_m0_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : avalon_m0_arbiter
//  Description : Two-requester arbiter in front of one Avalon-MM master port.
//                Grants one requester at a time and breaks ties in
//                round-robin order. Outstanding reads are tracked in an
//                owner FIFO so that each read return is steered to the
//                requester that issued the read.
//  Ports       : clk, reset (sync, active-low)
//                r0_*/r1_*    requester-side Avalon slave interfaces
//                r_readdata   read data broadcast to both requesters
//                avm_m0_*     shared downstream Avalon-MM master
//                pend_count   number of outstanding reads
//                err_unexp_rdv sticky: readdatavalid seen with nothing pending
//  Revision    : 1.0 - initial release
// ============================================================================
module avalon_m0_arbiter #(
    parameter int unsigned MAX_PEND = 8,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 256
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR_W-1:0]         r0_address,
    input  logic                      r0_read,
    input  logic                      r0_write,
    input  logic [DATA_W-1:0]         r0_writedata,
    output logic                      r0_waitrequest,
    output logic                      r0_readdatavalid,
    input  logic [ADDR_W-1:0]         r1_address,
    input  logic                      r1_read,
    input  logic                      r1_write,
    input  logic [DATA_W-1:0]         r1_writedata,
    output logic                      r1_waitrequest,
    output logic                      r1_readdatavalid,
    output logic [DATA_W-1:0]         r_readdata,
    output logic [ADDR_W-1:0]         avm_m0_address,
    output logic                      avm_m0_read,
    output logic                      avm_m0_write,
    output logic [DATA_W-1:0]         avm_m0_writedata,
    input  logic                      avm_m0_waitrequest,
    input  logic                      avm_m0_readdatavalid,
    input  logic [DATA_W-1:0]         avm_m0_readdata,
    output logic [$clog2(MAX_PEND):0] pend_count,
    output logic                      err_unexp_rdv
);

    localparam int unsigned c_ptr_w = $clog2(MAX_PEND);
    localparam int unsigned c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(MAX_PEND);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GNT0 = 2'd1,
        S_GNT1 = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_last_gnt;
    logic [MAX_PEND-1:0]  r_owner;
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_cnt_w-1:0]   r_pend_count;
    logic                 r_err;

    logic w_req0;
    logic w_req1;
    logic w_gnt0;
    logic w_gnt1;
    logic w_granted;
    logic w_sel_read;
    logic w_sel_write;
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_blk;
    logic w_accept;
    logic w_push;
    logic w_head;

    // Grant qualifiers are gated by reset so the command and stall outputs
    // are idle while reset is held, even before the first clock edge.
    assign w_req0      = r0_read | r0_write;
    assign w_req1      = r1_read | r1_write;
    assign w_gnt0      = reset && (r_state == S_GNT0);
    assign w_gnt1      = reset && (r_state == S_GNT1);
    assign w_granted   = w_gnt0 | w_gnt1;
    assign w_sel_read  = w_gnt1 ? r1_read  : r0_read;
    assign w_sel_write = w_gnt1 ? r1_write : r0_write;

    assign w_empty = (r_pend_count == '0);
    assign w_full  = (r_pend_count == c_full);

    // A return with nothing outstanding is dropped and flagged, never popped.
    assign w_pop = reset && avm_m0_readdatavalid && !w_empty;

    // A full FIFO frees a slot in the same cycle it pops, so a blocked read
    // may be accepted alongside a return (push and pop cancel out).
    assign w_blk    = w_granted && w_sel_read && w_full && !w_pop;
    assign w_accept = w_granted && (w_sel_read | w_sel_write)
                      && !avm_m0_waitrequest && !w_blk;
    // Read+write together is counted as a read.
    assign w_push   = w_accept && w_sel_read;

    assign w_head = r_owner[r_rd_ptr];

    assign avm_m0_address   = w_gnt1 ? r1_address   : r0_address;
    assign avm_m0_writedata = w_gnt1 ? r1_writedata : r0_writedata;
    assign avm_m0_read      = w_granted && w_sel_read  && !w_blk;
    assign avm_m0_write     = w_granted && w_sel_write && !w_blk;

    assign r0_waitrequest   = w_gnt0 ? (avm_m0_waitrequest | w_blk) : 1'b1;
    assign r1_waitrequest   = w_gnt1 ? (avm_m0_waitrequest | w_blk) : 1'b1;

    assign r0_readdatavalid = w_pop && !w_head;
    assign r1_readdatavalid = w_pop &&  w_head;
    assign r_readdata       = avm_m0_readdata;

    assign pend_count    = r_pend_count;
    assign err_unexp_rdv = r_err;

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req0 && w_req1) begin
                    w_state_nxt = r_last_gnt ? S_GNT0 : S_GNT1;
                end else if (w_req0) begin
                    w_state_nxt = S_GNT0;
                end else if (w_req1) begin
                    w_state_nxt = S_GNT1;
                end
            end
            S_GNT0: begin
                if (w_accept) begin
                    if (w_req1)      w_state_nxt = S_GNT1;
                    else if (w_req0) w_state_nxt = S_GNT0;
                    else             w_state_nxt = S_IDLE;
                end else if (!w_req0) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_GNT1: begin
                if (w_accept) begin
                    if (w_req0)      w_state_nxt = S_GNT0;
                    else if (w_req1) w_state_nxt = S_GNT1;
                    else             w_state_nxt = S_IDLE;
                end else if (!w_req1) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_last_gnt   <= 1'b1;
            r_owner      <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_pend_count <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_last_gnt <= w_gnt1;
            end
            if (w_push) begin
                r_owner[r_wr_ptr] <= w_gnt1;
                r_wr_ptr          <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_pend_count <= r_pend_count + 1'b1;
                2'b01:   r_pend_count <= r_pend_count - 1'b1;
                default: r_pend_count <= r_pend_count;
            endcase
            if (avm_m0_readdatavalid && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_avalon_m0_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_avalon_m0_arbiter
//  Description : Self-checking bench for avalon_m0_arbiter. Cycle vectors
//                carry stimulus and expected command/stall/count values;
//                read-return routing is predicted by a queue of expected
//                owners filled on each expected read accept.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_avalon_m0_arbiter;

    localparam int unsigned MAX_PEND = 8;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 256;

    localparam logic [ADDR_W-1:0] c_a0  = 32'h0000_1000;
    localparam logic [ADDR_W-1:0] c_a1  = 32'h0000_2000;
    localparam logic [DATA_W-1:0] c_wd0 = {32{8'hA5}};
    localparam logic [DATA_W-1:0] c_wd1 = {32{8'h5A}};

    logic               clk = 1'b0;
    logic               reset;
    logic               r0_read, r0_write, r1_read, r1_write;
    logic               r0_waitrequest, r0_readdatavalid;
    logic               r1_waitrequest, r1_readdatavalid;
    logic [DATA_W-1:0]  r_readdata;
    logic [ADDR_W-1:0]  avm_m0_address;
    logic               avm_m0_read, avm_m0_write;
    logic [DATA_W-1:0]  avm_m0_writedata;
    logic               avm_m0_waitrequest, avm_m0_readdatavalid;
    logic [DATA_W-1:0]  avm_m0_readdata;
    logic [3:0]         pend_count;
    logic               err_unexp_rdv;

    int n_checks = 0;
    int n_fail   = 0;
    int step     = 0;
    logic sb[$];

    always #5 clk = ~clk;

    avalon_m0_arbiter #(.MAX_PEND(MAX_PEND), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk                  (clk),
        .reset                (reset),
        .r0_address           (c_a0),
        .r0_read              (r0_read),
        .r0_write             (r0_write),
        .r0_writedata         (c_wd0),
        .r0_waitrequest       (r0_waitrequest),
        .r0_readdatavalid     (r0_readdatavalid),
        .r1_address           (c_a1),
        .r1_read              (r1_read),
        .r1_write             (r1_write),
        .r1_writedata         (c_wd1),
        .r1_waitrequest       (r1_waitrequest),
        .r1_readdatavalid     (r1_readdatavalid),
        .r_readdata           (r_readdata),
        .avm_m0_address       (avm_m0_address),
        .avm_m0_read          (avm_m0_read),
        .avm_m0_write         (avm_m0_write),
        .avm_m0_writedata     (avm_m0_writedata),
        .avm_m0_waitrequest   (avm_m0_waitrequest),
        .avm_m0_readdatavalid (avm_m0_readdatavalid),
        .avm_m0_readdata      (avm_m0_readdata),
        .pend_count           (pend_count),
        .err_unexp_rdv        (err_unexp_rdv)
    );

    typedef struct {
        logic rst_n;
        logic r0_rd, r0_wr, r1_rd, r1_wr;
        logic m_wait, m_rdv;
        logic e_rd, e_wr, e_w0, e_w1;
        logic e_own;
        logic acc;
        int   e_pend;
        logic e_err;
    } vec_t;

    function automatic vec_t mk(
        input logic rst_n,
        input logic r0r, input logic r0w, input logic r1r, input logic r1w,
        input logic mw, input logic mv,
        input logic erd, input logic ewr, input logic ew0, input logic ew1,
        input logic own, input logic acc, input int pend, input logic err);
        vec_t v;
        v.rst_n = rst_n;
        v.r0_rd = r0r; v.r0_wr = r0w; v.r1_rd = r1r; v.r1_wr = r1w;
        v.m_wait = mw; v.m_rdv = mv;
        v.e_rd = erd; v.e_wr = ewr; v.e_w0 = ew0; v.e_w1 = ew1;
        v.e_own = own; v.acc = acc; v.e_pend = pend; v.e_err = err;
        return v;
    endfunction

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step=%0d got=%0h exp=%0h", name, step, act, exp);
        end
    endtask

    // One clock cycle: drive, check mid-cycle, then advance past the edge.
    task automatic apply(input vec_t v);
        logic [31:0]       s;
        logic [DATA_W-1:0] rdata;
        logic              own;
        logic              e_v0;
        logic              e_v1;
        s     = step;
        rdata = {8{s}};
        reset                = v.rst_n;
        r0_read              = v.r0_rd;
        r0_write             = v.r0_wr;
        r1_read              = v.r1_rd;
        r1_write             = v.r1_wr;
        avm_m0_waitrequest   = v.m_wait;
        avm_m0_readdatavalid = v.m_rdv;
        avm_m0_readdata      = rdata;
        #4;
        e_v0 = 1'b0;
        e_v1 = 1'b0;
        if (!v.rst_n) sb.delete();
        if (v.rst_n && v.m_rdv && sb.size() > 0) begin
            own  = sb.pop_front();
            e_v0 = !own;
            e_v1 = own;
        end
        check("avm_read",  DATA_W'(avm_m0_read),      DATA_W'(v.e_rd));
        check("avm_write", DATA_W'(avm_m0_write),     DATA_W'(v.e_wr));
        check("r0_wait",   DATA_W'(r0_waitrequest),   DATA_W'(v.e_w0));
        check("r1_wait",   DATA_W'(r1_waitrequest),   DATA_W'(v.e_w1));
        check("r0_rdv",    DATA_W'(r0_readdatavalid), DATA_W'(e_v0));
        check("r1_rdv",    DATA_W'(r1_readdatavalid), DATA_W'(e_v1));
        check("pend",      DATA_W'(pend_count),       DATA_W'(v.e_pend));
        check("err",       DATA_W'(err_unexp_rdv),    DATA_W'(v.e_err));
        check("rdata",     r_readdata,                rdata);
        if (v.e_rd || v.e_wr)
            check("addr", DATA_W'(avm_m0_address), DATA_W'(v.e_own ? c_a1 : c_a0));
        if (v.e_wr)
            check("wdata", avm_m0_writedata, v.e_own ? c_wd1 : c_wd0);
        if (v.rst_n && v.acc) sb.push_back(v.e_own);
        @(posedge clk);
        #1;
        step++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog step=%0d got=timeout exp=finish", step);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[22];
        // rst  r0r r0w r1r r1w  mw mv  erd ewr ew0 ew1  own acc pend err
        // Both requesters read from idle: r0 first, then r1; returns r0, r1
        tbl[0]  = mk(1, 1,0,1,0, 0,0, 0,0,1,1, 0,0, 0,0);
        tbl[1]  = mk(1, 1,0,1,0, 0,0, 1,0,0,1, 0,1, 0,0);
        tbl[2]  = mk(1, 0,0,1,0, 0,0, 1,0,1,0, 1,1, 1,0);
        tbl[3]  = mk(1, 0,0,0,0, 0,0, 0,0,1,0, 1,0, 2,0);
        tbl[4]  = mk(1, 0,0,0,0, 0,1, 0,0,1,1, 0,0, 2,0);
        tbl[5]  = mk(1, 0,0,0,0, 0,1, 0,0,1,1, 0,0, 1,0);
        tbl[6]  = mk(1, 0,0,0,0, 0,0, 0,0,1,1, 0,0, 0,0);
        // r0 write stalled 3 cycles while r1 waits; then r1 granted
        tbl[7]  = mk(1, 0,1,1,0, 1,0, 0,0,1,1, 0,0, 0,0);
        tbl[8]  = mk(1, 0,1,1,0, 1,0, 0,1,1,1, 0,0, 0,0);
        tbl[9]  = mk(1, 0,1,1,0, 1,0, 0,1,1,1, 0,0, 0,0);
        tbl[10] = mk(1, 0,1,1,0, 1,0, 0,1,1,1, 0,0, 0,0);
        tbl[11] = mk(1, 0,1,1,0, 0,0, 0,1,0,1, 0,0, 0,0);
        tbl[12] = mk(1, 0,0,1,0, 0,0, 1,0,1,0, 1,1, 0,0);
        tbl[13] = mk(1, 0,0,0,0, 0,0, 0,0,1,0, 1,0, 1,0);
        tbl[14] = mk(1, 0,0,0,0, 0,1, 0,0,1,1, 0,0, 1,0);
        tbl[15] = mk(1, 0,0,0,0, 0,0, 0,0,1,1, 0,0, 0,0);
        // Interleaved r0,r1,r0 reads with returns overlapping accepts
        tbl[16] = mk(1, 1,0,1,0, 0,0, 0,0,1,1, 0,0, 0,0);
        tbl[17] = mk(1, 1,0,1,0, 0,0, 1,0,0,1, 0,1, 0,0);
        tbl[18] = mk(1, 1,0,1,0, 0,1, 1,0,1,0, 1,1, 1,0);
        tbl[19] = mk(1, 1,0,0,0, 0,1, 1,0,0,1, 0,1, 1,0);
        tbl[20] = mk(1, 0,0,0,0, 0,1, 0,0,0,1, 0,0, 1,0);
        tbl[21] = mk(1, 0,0,0,0, 0,0, 0,0,1,1, 0,0, 0,0);

        reset = 1'b0;
        r0_read = 1'b0; r0_write = 1'b0; r1_read = 1'b0; r1_write = 1'b0;
        avm_m0_waitrequest = 1'b0; avm_m0_readdatavalid = 1'b0;
        avm_m0_readdata = '0;
        @(posedge clk);
        #1;

        // Reset state, with requests present
        apply(mk(0, 1,0,1,0, 0,1, 0,0,1,1, 0,0, 0,0));
        apply(mk(0, 0,0,0,0, 0,0, 0,0,1,1, 0,0, 0,0));

        for (int i = 0; i < 22; i++) apply(tbl[i]);

        // r1 issues 9 reads with no returns: 9th blocked until a return
        apply(mk(1, 0,0,1,0, 0,0, 0,0,1,1, 0,0, 0,0));
        for (int i = 0; i < 8; i++) apply(mk(1, 0,0,1,0, 0,0, 1,0,1,0, 1,1, i,0));
        for (int i = 0; i < 2; i++) apply(mk(1, 0,0,1,0, 0,0, 0,0,1,1, 1,0, 8,0));
        apply(mk(1, 0,0,1,0, 0,1, 1,0,1,0, 1,1, 8,0));
        apply(mk(1, 0,0,0,0, 0,0, 0,0,1,0, 1,0, 8,0));
        for (int i = 0; i < 8; i++) apply(mk(1, 0,0,0,0, 0,1, 0,0,1,1, 0,0, 8-i,0));
        apply(mk(1, 0,0,0,0, 0,0, 0,0,1,1, 0,0, 0,0));

        // Stray return with nothing pending: flagged, sticky
        apply(mk(1, 0,0,0,0, 0,1, 0,0,1,1, 0,0, 0,0));
        apply(mk(1, 0,0,0,0, 0,0, 0,0,1,1, 0,0, 0,1));
        apply(mk(1, 0,0,0,0, 0,0, 0,0,1,1, 0,0, 0,1));

        // Reset with 3 reads pending, then a stray return afterwards
        apply(mk(1, 1,0,0,0, 0,0, 0,0,1,1, 0,0, 0,1));
        for (int i = 0; i < 3; i++) apply(mk(1, 1,0,0,0, 0,0, 1,0,0,1, 0,1, i,1));
        apply(mk(0, 1,0,0,0, 0,0, 0,0,1,1, 0,0, 3,1));
        apply(mk(0, 1,0,0,0, 0,1, 0,0,1,1, 0,0, 0,0));
        apply(mk(1, 0,0,0,0, 0,1, 0,0,1,1, 0,0, 0,0));
        apply(mk(1, 0,0,0,0, 0,0, 0,0,1,1, 0,0, 0,1));

        check("sb_empty", DATA_W'(sb.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
